tablet_bottling_system: RTL and testbench
=========================================

// Module: tablet_bottling_system
// PURPOSE
//   Counts tablets dropping past a sensor into the current bottle and closes the
//   feed valve once the operator-set target count is reached. Keeps a running total
//   of all tablets dispensed. Sits between the keypad/conveyor controls and the
//   dispensing valve actuator, in one clock domain.
// PARAMETERS
//   KEY_W    4    width of keypad_in (target entry value)
//   COUNT_W  8    width of current_count and target_limit
//   TOTAL_W  16   width of total_tablets
// PORTS
//   clk                input   1        system clock, rising-edge active
//   reset              input   1        asynchronous, active-low reset (0 = reset)
//   load_target_btn    input   1        synchronous level; when 1, load keypad_in as target
//   keypad_in          input   KEY_W    target value entered on keypad
//   sensor_pulse       input   1        tablet sensor; each 0->1 transition = one tablet
//   new_bottle_signal  input   1        conveyor advanced; start a fresh bottle
//   valve_close        output  1        1 = feed valve closed (no dispensing)
//   current_count      output  COUNT_W  tablets counted into the current bottle
//   target_limit       output  COUNT_W  active target, keypad_in zero-extended
//   total_tablets      output  TOTAL_W  tablets counted since reset
// BEHAVIOUR
//   Reset (reset==0, async): state=IDLE, current_count=0, target_limit=0,
//     total_tablets=0, valve_close=1, sensor edge register=0.
//   All inputs are treated as synchronous to clk; no input synchronizers.
//   Edge detect: register sensor_pulse each clock. A tablet event occurs in the cycle
//     where sensor_pulse==1 and the registered value==0. A high level counts once only.
//   FSM, all outputs registered:
//     IDLE    (target_limit==0): valve_close=1. Tablet events ignored.
//     FILLING (current_count < target_limit): valve_close=0.
//     FULL    (current_count >= target_limit, target!=0): valve_close=1. Events ignored.
//   Tablet event in FILLING: current_count+1 and total_tablets+1 at the same edge.
//     If the new count equals target_limit, go to FULL at that edge. valve_close=1
//     therefore shows in the same cycle as the final count, 1 clock after the event cycle.
//   load_target_btn==1: target_limit <= {0, keypad_in} at the next edge. current_count
//     is kept. Next state comes from the new target: 0 -> IDLE;
//     count >= target -> FULL; otherwise FILLING. A held button reloads every cycle.
//   new_bottle_signal==1: current_count <= 0 at the next edge. Next state is FILLING
//     if target_limit!=0, else IDLE. total_tablets is kept.
//   Priority in one cycle: new_bottle_signal > load_target_btn > tablet event.
//     A tablet event in a cycle with new_bottle_signal or load_target_btn is dropped.
//     If both controls are active, the count clears and the target loads, and the
//     state comes from count 0 and the new target.
//   total_tablets saturates at all-ones and does not wrap. current_count saturates at
//     all-ones. It cannot exceed target_limit in normal operation.
//   Async reset mid-fill clears everything immediately. Any count in progress is lost.
// TESTING
//   1. Assert reset low 20ns, release -> count=0, target=0, total=0, valve_close=1.
//   2. keypad_in=5, load 1 cycle; five 1-cycle sensor pulses -> count=5, total=5,
//      valve_close=1 after the 5th. Extra pulses leave count at 5 and total at 5.
//   3. new_bottle_signal 1 cycle -> count=0, valve_close=0, target=5, total=5.
//      Five more pulses -> count=5, total=10, valve_close=1.
//   4. sensor_pulse held high for 4 cycles in FILLING -> count +1 only.
//      Pulse coinciding with new_bottle_signal -> not counted; count=0.
//   5. target=5, count=3; load keypad_in=2 -> target=2, FULL, valve_close=1.
//      Load keypad_in=0 -> IDLE, valve_close=1, pulses ignored.
//   6. Drive reset low between pulses mid-fill (count=3) -> all outputs return to
//      reset values asynchronously. Also preload total near 0xFFFF and pulse ->
//      total saturates at 0xFFFF.

Source files
------------

// File: rtl/tablet_bottling_system.sv
// rtl/tablet_bottling_system.sv - tablet counter with target-limited feed valve and running total
// A bottle fills until the keypad target is reached. All outputs are registered in one always_ff.
module tablet_bottling_system #(
  parameter int KEY_W   = 4,
  parameter int COUNT_W = 8,
  parameter int TOTAL_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_target_btn,
  input  logic [KEY_W-1:0]   keypad_in,
  input  logic               sensor_pulse,
  input  logic               new_bottle_signal,
  output logic               valve_close,
  output logic [COUNT_W-1:0] current_count,
  output logic [COUNT_W-1:0] target_limit,
  output logic [TOTAL_W-1:0] total_tablets
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } state_t;

  state_t             state;
  logic               sensor_q;
  logic               tablet_event;
  logic [COUNT_W-1:0] key_target;
  logic [COUNT_W-1:0] bottle_target;
  logic [COUNT_W-1:0] count_inc;
  logic [TOTAL_W-1:0] total_inc;

  assign tablet_event  = sensor_pulse & ~sensor_q;
  assign key_target    = {{(COUNT_W-KEY_W){1'b0}}, keypad_in};
  // A new bottle with a simultaneous load starts from the freshly keyed target.
  assign bottle_target = load_target_btn ? key_target : target_limit;
  assign count_inc     = (&current_count) ? current_count : current_count + 1'b1;
  assign total_inc     = (&total_tablets) ? total_tablets : total_tablets + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      sensor_q      <= 1'b0;
      valve_close   <= 1'b1;
      current_count <= '0;
      target_limit  <= '0;
      total_tablets <= '0;
    end else begin
      sensor_q <= sensor_pulse;
      if (new_bottle_signal) begin
        current_count <= '0;
        target_limit  <= bottle_target;
        if (bottle_target == '0) begin
          state       <= IDLE;
          valve_close <= 1'b1;
        end else begin
          state       <= FILLING;
          valve_close <= 1'b0;
        end
      end else if (load_target_btn) begin
        target_limit <= key_target;
        if (key_target == '0) begin
          state       <= IDLE;
          valve_close <= 1'b1;
        end else if (current_count >= key_target) begin
          state       <= FULL;
          valve_close <= 1'b1;
        end else begin
          state       <= FILLING;
          valve_close <= 1'b0;
        end
      end else if (tablet_event && state == FILLING) begin
        current_count <= count_inc;
        total_tablets <= total_inc;
        // The valve closes on the same edge that records the final tablet.
        if (count_inc >= target_limit) begin
          state       <= FULL;
          valve_close <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tablet_bottling_system.sv
// tb/tb_tablet_bottling_system.sv - scoreboard bench for tablet_bottling_system
module tb_tablet_bottling_system;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_target_btn = 1'b0;
  logic [3:0]  keypad_in = 4'd0;
  logic        sensor_pulse = 1'b0;
  logic        new_bottle_signal = 1'b0;
  logic        valve_close;
  logic [7:0]  current_count;
  logic [7:0]  target_limit;
  logic [15:0] total_tablets;

  tablet_bottling_system dut (
    .clk(clk),
    .reset(reset),
    .load_target_btn(load_target_btn),
    .keypad_in(keypad_in),
    .sensor_pulse(sensor_pulse),
    .new_bottle_signal(new_bottle_signal),
    .valve_close(valve_close),
    .current_count(current_count),
    .target_limit(target_limit),
    .total_tablets(total_tablets)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       name;
    logic [7:0]  c;
    logic [7:0]  t;
    logic [15:0] tot;
    logic        v;
  } exp_t;

  exp_t q[$];
  int   mcyc = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [7:0] c, input logic [7:0] t,
                     input logic [15:0] tot, input logic v);
    checks++;
    if (current_count !== c || target_limit !== t || total_tablets !== tot || valve_close !== v) begin
      errors++;
      $display("FAIL %s: got count=%0d target=%0d total=%h valve=%b, want count=%0d target=%0d total=%h valve=%b",
               name, current_count, target_limit, total_tablets, valve_close, c, t, tot, v);
    end
  endtask

  // Monitor: samples 2ns after each rising edge and retires expectations due at that edge.
  initial forever begin
    exp_t e;
    @(posedge clk);
    mcyc++;
    #2;
    while (q.size() > 0 && q[0].cyc <= mcyc) begin
      e = q.pop_front();
      if (e.cyc < mcyc) begin
        checks++;
        errors++;
        $display("FAIL %s: expectation for cycle %0d seen at cycle %0d", e.name, e.cyc, mcyc);
      end else begin
        chk(e.name, e.c, e.t, e.tot, e.v);
      end
    end
  end

  task automatic tick(input logic ld, input logic [3:0] key, input logic sp, input logic nb);
    load_target_btn   = ld;
    keypad_in         = key;
    sensor_pulse      = sp;
    new_bottle_signal = nb;
    @(negedge clk);
  endtask

  task automatic tickx(input logic ld, input logic [3:0] key, input logic sp, input logic nb,
                       input string name, input logic [7:0] c, input logic [7:0] t,
                       input logic [15:0] tot, input logic v);
    exp_t e;
    e.cyc = mcyc + 1;
    e.name = name;
    e.c = c;
    e.t = t;
    e.tot = tot;
    e.v = v;
    q.push_back(e);
    tick(ld, key, sp, nb);
  endtask

  initial begin
    // 1: reset held low for 20ns
    #12;
    chk("reset_hold", 8'd0, 8'd0, 16'h0000, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    tickx(0, 0, 0, 0, "after_reset", 0, 0, 16'd0, 1);
    tickx(0, 0, 1, 0, "idle_ignores", 0, 0, 16'd0, 1);
    tick(0, 0, 0, 0);

    // 2: target 5, fill to full, extra pulse ignored
    tickx(1, 4'd5, 0, 0, "load5", 0, 5, 16'd0, 0);
    for (int i = 1; i <= 5; i++) begin
      tickx(0, 0, 1, 0, $sformatf("fill1_%0d", i), 8'(i), 5, 16'(i), (i == 5));
      tick(0, 0, 0, 0);
    end
    tickx(0, 0, 1, 0, "full_ignores", 5, 5, 16'd5, 1);
    tick(0, 0, 0, 0);

    // 3: new bottle, second fill
    tickx(0, 0, 0, 1, "newb1", 0, 5, 16'd5, 0);
    for (int i = 1; i <= 5; i++) begin
      tickx(0, 0, 1, 0, $sformatf("fill2_%0d", i), 8'(i), 5, 16'(5 + i), (i == 5));
      tick(0, 0, 0, 0);
    end

    // 4: held level counts once; pulse with new bottle dropped
    tickx(0, 0, 0, 1, "newb2", 0, 5, 16'd10, 0);
    tickx(0, 0, 1, 0, "hold_1", 1, 5, 16'd11, 0);
    tickx(0, 0, 1, 0, "hold_2", 1, 5, 16'd11, 0);
    tickx(0, 0, 1, 0, "hold_3", 1, 5, 16'd11, 0);
    tickx(0, 0, 1, 0, "hold_4", 1, 5, 16'd11, 0);
    tick(0, 0, 0, 0);
    tickx(0, 0, 1, 1, "pulse_with_newb", 0, 5, 16'd11, 0);
    tick(0, 0, 0, 0);

    // 5: retarget below count, then to zero; load beats a pulse
    for (int i = 1; i <= 3; i++) begin
      tickx(0, 0, 1, 0, $sformatf("fill3_%0d", i), 8'(i), 5, 16'(11 + i), 0);
      tick(0, 0, 0, 0);
    end
    tickx(1, 4'd2, 1, 0, "load2_full", 3, 2, 16'd14, 1);
    tick(0, 0, 0, 0);
    tickx(1, 4'd0, 0, 0, "load0_idle", 3, 0, 16'd14, 1);
    tickx(0, 0, 1, 0, "idle_ignores2", 3, 0, 16'd14, 1);
    tick(0, 0, 0, 0);
    tickx(1, 4'd4, 1, 1, "load_and_newb", 0, 4, 16'd14, 0);
    tick(0, 0, 0, 0);

    // 6: async reset mid-fill
    for (int i = 1; i <= 3; i++) begin
      tickx(0, 0, 1, 0, $sformatf("fill4_%0d", i), 8'(i), 4, 16'(14 + i), 0);
      tick(0, 0, 0, 0);
    end
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset", 0, 0, 16'h0000, 1);
    @(negedge clk);
    reset = 1'b1;
    tickx(1, 4'd3, 0, 0, "load3", 0, 3, 16'd0, 0);

    // total saturation from a preloaded value
    force dut.total_tablets = 16'hFFFE;
    #1;
    release dut.total_tablets;
    @(negedge clk);
    tickx(0, 0, 1, 0, "sat_1", 1, 3, 16'hFFFF, 0);
    tick(0, 0, 0, 0);
    tickx(0, 0, 1, 0, "sat_2", 2, 3, 16'hFFFF, 0);
    tick(0, 0, 0, 0);
    tickx(0, 0, 1, 0, "sat_3", 3, 3, 16'hFFFF, 1);
    tick(0, 0, 0, 0);

    repeat (4) @(negedge clk);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: expectation never retired", e.name);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
